// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable baud divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        div_q, div_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               ovf_q, ovf_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         fifo_mem_q [FIFO_DEPTH];
  logic [7:0]         fifo_mem_d [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  logic       hit;
  logic [1:0] off;
  logic       full, empty, push_req, push, pop, bit_end;
  logic [7:0] head;
  logic       unused_bits;

  assign hit      = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign off      = addr_i[3:2];
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push_req = wr_en_i && hit && (off == 2'd0);
  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign push     = push_req && !full;
  assign bit_end  = (cnt_q == div_q - 16'd1);
  assign head     = fifo_mem_q[rd_ptr_q];
  assign tx_o     = tx_q;
  assign unused_bits = ^{data_i[31:16], addr_i[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 16'd1;
    end
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      shift_d   = head;
      div_d     = baud_q;
      cnt_d     = '0;
      bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
      par_d     = ^head;
`endif
    end
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    baud_d     = baud_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = data_i[7:0];
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req && full) begin
      ovf_d = 1'b1;
    end else if (wr_en_i && hit && (off == 2'd1) && data_i[3]) begin
      ovf_d = 1'b0;
    end
    if (wr_en_i && hit && (off == 2'd2)) begin
      baud_d = (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
    end
  end

  always_comb begin
    data_o = '0;
    if (hit) begin
      case (off)
        2'd1:    data_o = {19'd0, 5'(count_q), 4'd0, ovf_q, empty, full, (state_q != S_IDLE)};
        2'd2:    data_o = {16'd0, baud_q};
        default: data_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= DEFAULT_DIV;
      baud_q    <= DEFAULT_DIV;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed register accesses plus a serial-line monitor
// that decodes frames and checks them against a queue of expected bytes.
module tb_uart_tx_mmio;
  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_BD  = 32'h1000_0008;
  localparam logic [31:0] A_RSV = 32'h1000_000C;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] data_o;
  logic        tx_o;

  int          checks_total = 0;
  int          checks_pass = 0;
  int unsigned cyc = 0;
  int unsigned mon_div = 4;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];

  uart_tx_mmio #(
    .BASE_ADDR  (32'h1000_0000),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd434)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en_i(wr_en),
    .addr_i (addr),
    .data_i (wdata),
    .data_o (data_o),
    .tx_o   (tx_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, data_o, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int unsigned base, input int unsigned exp_len);
    addr = A_ST;
    for (int unsigned i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      if (!data_o[0]) break;
    end
    check(name, cyc - base, exp_len);
  endtask

  // Decodes one frame starting at the first low sample of the start bit.
  task automatic rx_frame();
    logic [7:0]  b;
    logic        e;
    logic [31:0] exp;
    int unsigned bad;
    int unsigned div;
    b   = '0;
    bad = 0;
    div = mon_div;
    start_q.push_back(cyc);
    for (int unsigned k = 0; k < FRAME_BITS; k++) begin
      for (int unsigned c = 0; c < div; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (!rst_n) begin
          exp_q.delete();
          return;
        end
        if (k >= 1 && k <= 8 && c == 0) b[k-1] = tx_o;
        if (k == 0) e = 1'b0;
        else if (k <= 8) e = b[k-1];
        else if (k == FRAME_BITS - 1) e = 1'b1;
        else e = ^b;
        if (tx_o !== e) bad++;
      end
    end
    check("frame_shape", bad, 0);
    exp = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'hDEAD_BEEF;
    check("frame_byte", {24'd0, b}, exp);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && tx_o === 1'b0) rx_frame();
    end
  end

  initial begin : stim
    int unsigned pop_cyc;
    int unsigned gap;

    tick(3);
    rst_n = 1'b1;
    check("reset_tx", {31'd0, tx_o}, 32'd1);
    rd_check("reset_status", A_ST, 32'h0000_0004);
    rd_check("reset_baud", A_BD, 32'd434);
    rd_check("txdata_reads_zero", A_TX, 32'd0);
    rd_check("reserved_zero", A_RSV, 32'd0);
    rd_check("miss_window_far", 32'h2000_0004, 32'd0);
    rd_check("miss_window_near", 32'h1000_0014, 32'd0);
    wr(A_BD, 32'd0);
    rd_check("baud_zero_as_one", A_BD, 32'd1);
    wr(A_BD, 32'hFFFF_0004);
    rd_check("baud_write_4", A_BD, 32'd4);

    mon_div = 4;
    exp_q.push_back(8'h55);
    wr(A_TX, 32'h0000_3355);
    rd_check("count_after_push", A_ST, 32'h0000_0100);
    tick(1);
    pop_cyc = cyc;
    check("tx_low_after_pop", {31'd0, tx_o}, 32'd0);
    rd_check("busy_after_pop", A_ST, 32'h0000_0005);
    wait_idle("frame_len_55", pop_cyc, 4 * FRAME_BITS);

    start_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    wr(A_TX, 32'hA5);
    wr(A_TX, 32'h3C);
    pop_cyc = cyc;
    wait_idle("b2b_len", pop_cyc, 8 * FRAME_BITS);
    check("b2b_frames_seen", start_q.size(), 2);
    gap = (start_q.size() >= 2) ? start_q[1] - start_q[0] : 0;
    check("b2b_no_gap", gap, 4 * FRAME_BITS);

    wr(A_BD, 32'd434);
    mon_div = 434;
    for (int unsigned i = 1; i <= 9; i++) begin
      exp_q.push_back(8'(i));
      wr(A_TX, i);
    end
    rd_check("fill_8_no_drop", A_ST, 32'h0000_0803);
    wr(A_TX, 32'h0A);
    rd_check("overflow_set", A_ST, 32'h0000_080B);
    wr(A_ST, 32'h0000_0007);
    rd_check("overflow_kept_w0", A_ST, 32'h0000_080B);
    wr(A_ST, 32'h0000_0008);
    rd_check("overflow_clear", A_ST, 32'h0000_0803);
    wr(A_RSV, 32'h0000_0055);
    rd_check("rsvd_write_ignored", A_BD, 32'd434);
    wr(A_BD, 32'd100);

    tick(1500);
    check("mid_data_busy", {31'd0, tx_o === 1'b1 || tx_o === 1'b0}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("reset_mid_tx", {31'd0, tx_o}, 32'd1);
    rd_check("reset_mid_status", A_ST, 32'h0000_0004);
    rd_check("reset_mid_baud", A_BD, 32'd434);
    tick(20);
    check("idle_after_reset", {31'd0, tx_o}, 32'd1);

    wr(A_BD, 32'd4);
    mon_div = 4;
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h03);
    wr(A_TX, 32'h07);
    wr(A_TX, 32'h03);
    pop_cyc = cyc;
    rd_check("push_pop_same_edge", A_ST, 32'h0000_0101);
    wait_idle("parity_pair_len", pop_cyc, 8 * FRAME_BITS);

    tick(5);
    check("all_frames_received", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end
endmodule
